// File: rtl/pic_cmd_sequencer.sv
// Command front end for an 8259-style PIC: synchronises the CPU strobes,
// runs the ICW1..ICW4 initialisation sequence, decodes OCW1..OCW3 and
// registers the CPU read-back mux.
module pic_cmd_sequencer #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              wr_n,
  input  logic              rd_n,
  input  logic              a0,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_oe,
  input  logic [DATA_W-1:0] irr_in,
  input  logic [DATA_W-1:0] isr_in,
  output logic [DATA_W-1:0] icw1,
  output logic [DATA_W-1:0] icw2,
  output logic [DATA_W-1:0] icw3,
  output logic [DATA_W-1:0] icw4,
  output logic [DATA_W-1:0] imr,
  output logic [DATA_W-1:0] ocw2_data,
  output logic              cmd_valid,
  output logic              cmd_type,
  output logic [1:0]        cmd_nr,
  output logic              init_done,
  output logic              seq_err
);

  // All CPU-side signals share one pipeline so a0/din/cs_n stay aligned with the strobes.
  typedef struct packed {
    logic              cs_n;
    logic              wr_n;
    logic              rd_n;
    logic              a0;
    logic [DATA_W-1:0] din;
  } bus_t;

  typedef enum logic [2:0] {
    ST_UNINIT = 3'd0,
    ST_ICW2   = 3'd1,
    ST_ICW3   = 3'd2,
    ST_ICW4   = 3'd3,
    ST_READY  = 3'd4
  } state_t;

  // Stages 0..SYNC_STAGES-1 synchronise; stage SYNC_STAGES is the prior sample used for edge detect.
  bus_t [SYNC_STAGES:0] sync_q, sync_d;

  state_t state_q, state_d;

  logic [DATA_W-1:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
  logic [DATA_W-1:0] imr_q, imr_d, ocw2_q, ocw2_d, dout_q, dout_d;
  logic              sel_q, sel_d;
  logic              cmd_valid_q, cmd_valid_d, cmd_type_q, cmd_type_d;
  logic [1:0]        cmd_nr_q, cmd_nr_d;
  logic              init_done_q, init_done_d, seq_err_q, seq_err_d;
  logic              dout_oe_q, dout_oe_d;

  logic              cs_s, wr_s, rd_s, a0_s;
  logic              cs_p, wr_p, rd_p, a0_p;
  logic [DATA_W-1:0] din_p;
  logic              commit, is_icw1, both_s, both_p;

  assign cs_s  = sync_q[SYNC_STAGES-1].cs_n;
  assign wr_s  = sync_q[SYNC_STAGES-1].wr_n;
  assign rd_s  = sync_q[SYNC_STAGES-1].rd_n;
  assign a0_s  = sync_q[SYNC_STAGES-1].a0;
  assign cs_p  = sync_q[SYNC_STAGES].cs_n;
  assign wr_p  = sync_q[SYNC_STAGES].wr_n;
  assign rd_p  = sync_q[SYNC_STAGES].rd_n;
  assign a0_p  = sync_q[SYNC_STAGES].a0;
  assign din_p = sync_q[SYNC_STAGES].din;

  // A write commits on the synced rising edge of wr_n; data comes from the sample before the edge.
  assign commit  = !wr_p && wr_s && !cs_p && rd_s;
  assign is_icw1 = !a0_p && din_p[4];
  // Simultaneous RD and WR is a bus error, flagged once on entry.
  assign both_s  = !rd_s && !wr_s && !cs_s;
  assign both_p  = !rd_p && !wr_p && !cs_p;

  // Shift the CPU signals one stage per clock.
  always_comb begin
    sync_d[0].cs_n = cs_n;
    sync_d[0].wr_n = wr_n;
    sync_d[0].rd_n = rd_n;
    sync_d[0].a0   = a0;
    sync_d[0].din  = din;
    for (int i = 1; i <= SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // Synchroniser flops; strobes reset inactive so no edge is seen coming out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= SYNC_STAGES; i++) begin
        sync_q[i].cs_n <= 1'b1;
        sync_q[i].wr_n <= 1'b1;
        sync_q[i].rd_n <= 1'b1;
        sync_q[i].a0   <= 1'b0;
        sync_q[i].din  <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_UNINIT;
    else     state_q <= state_d;
  end

  // Next state: ICW1 restarts from anywhere; ICW3 skipped in single mode, ICW4 unless IC4 set.
  always_comb begin
    state_d = state_q;
    if (commit) begin
      if (is_icw1) begin
        state_d = ST_ICW2;
      end else begin
        case (state_q)
          ST_ICW2: if (a0_p) state_d = !icw1_q[1] ? ST_ICW3 : (icw1_q[0] ? ST_ICW4 : ST_READY);
          ST_ICW3: if (a0_p) state_d = icw1_q[0] ? ST_ICW4 : ST_READY;
          ST_ICW4: if (a0_p) state_d = ST_READY;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // Command decode, register updates and read-back mux.
  always_comb begin
    icw1_d      = icw1_q;
    icw2_d      = icw2_q;
    icw3_d      = icw3_q;
    icw4_d      = icw4_q;
    imr_d       = imr_q;
    ocw2_d      = ocw2_q;
    sel_d       = sel_q;
    cmd_valid_d = 1'b0;
    cmd_type_d  = cmd_type_q;
    cmd_nr_d    = cmd_nr_q;
    seq_err_d   = both_s && !both_p;
    if (commit) begin
      if (is_icw1) begin
        icw1_d      = din_p;
        icw2_d      = '0;
        icw3_d      = '0;
        icw4_d      = '0;
        imr_d       = '0;
        sel_d       = 1'b0;
        cmd_valid_d = 1'b1;
        cmd_type_d  = 1'b1;
        cmd_nr_d    = 2'd0;
      end else begin
        case (state_q)
          ST_ICW2, ST_ICW3, ST_ICW4: begin
            if (a0_p) begin
              cmd_valid_d = 1'b1;
              cmd_type_d  = 1'b1;
              if (state_q == ST_ICW2) begin
                icw2_d   = din_p;
                cmd_nr_d = 2'd1;
              end else if (state_q == ST_ICW3) begin
                icw3_d   = din_p;
                cmd_nr_d = 2'd2;
              end else begin
                icw4_d   = din_p;
                cmd_nr_d = 2'd3;
              end
            end else begin
              seq_err_d = 1'b1;
            end
          end
          ST_READY: begin
            cmd_valid_d = 1'b1;
            cmd_type_d  = 1'b0;
            if (a0_p) begin
              imr_d    = din_p;
              cmd_nr_d = 2'd0;
            end else if (!din_p[3]) begin
              ocw2_d   = din_p;
              cmd_nr_d = 2'd1;
            end else begin
              if (din_p[1]) sel_d = din_p[0];
              cmd_nr_d = 2'd2;
            end
          end
          default: seq_err_d = 1'b1;
        endcase
      end
    end
    init_done_d = (state_d == ST_READY);
    dout_d      = a0_s ? imr_q : (sel_q ? isr_in : irr_in);
    dout_oe_d   = !rd_s && !cs_s && wr_s;
  end

  // Output and programmed-state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      icw1_q      <= '0;
      icw2_q      <= '0;
      icw3_q      <= '0;
      icw4_q      <= '0;
      imr_q       <= '0;
      ocw2_q      <= '0;
      sel_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= 1'b0;
      cmd_nr_q    <= 2'd0;
      init_done_q <= 1'b0;
      seq_err_q   <= 1'b0;
      dout_q      <= '0;
      dout_oe_q   <= 1'b0;
    end else begin
      icw1_q      <= icw1_d;
      icw2_q      <= icw2_d;
      icw3_q      <= icw3_d;
      icw4_q      <= icw4_d;
      imr_q       <= imr_d;
      ocw2_q      <= ocw2_d;
      sel_q       <= sel_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_nr_q    <= cmd_nr_d;
      init_done_q <= init_done_d;
      seq_err_q   <= seq_err_d;
      dout_q      <= dout_d;
      dout_oe_q   <= dout_oe_d;
    end
  end

  assign icw1      = icw1_q;
  assign icw2      = icw2_q;
  assign icw3      = icw3_q;
  assign icw4      = icw4_q;
  assign imr       = imr_q;
  assign ocw2_data = ocw2_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_type  = cmd_type_q;
  assign cmd_nr    = cmd_nr_q;
  assign init_done = init_done_q;
  assign seq_err   = seq_err_q;
  assign dout      = dout_q;
  assign dout_oe   = dout_oe_q;

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Scoreboard bench for pic_cmd_sequencer: stimulus pushes expected events,
// a monitor pops them on cmd_valid / seq_err / rising dout_oe.
module tb_pic_cmd_sequencer;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, a0 = 1'b0;
  logic [DW-1:0] din = '0, irr_in = '0, isr_in = '0;
  logic [DW-1:0] dout, icw1, icw2, icw3, icw4, imr, ocw2_data;
  logic          dout_oe, cmd_valid, cmd_type, init_done, seq_err;
  logic [1:0]    cmd_nr;

  pic_cmd_sequencer #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0), .din(din),
    .dout(dout), .dout_oe(dout_oe), .irr_in(irr_in), .isr_in(isr_in),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .imr(imr), .ocw2_data(ocw2_data),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_nr(cmd_nr),
    .init_done(init_done), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // kind: 0 command, 1 seq_err, 2 read. rid selects a register to check with a command.
  typedef struct {
    int            kind;
    logic          typ;
    logic [1:0]    nr;
    logic          done;
    int            rid;
    logic [DW-1:0] val;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] reg_val(input int rid);
    case (rid)
      1: return icw1;
      2: return icw2;
      3: return icw3;
      4: return icw4;
      5: return imr;
      6: return ocw2_data;
      default: return '0;
    endcase
  endfunction

  task automatic push_cmd(input logic t, input logic [1:0] n, input logic d, input int rid, input logic [DW-1:0] v);
    exp_t e;
    e.kind = 0; e.typ = t; e.nr = n; e.done = d; e.rid = rid; e.val = v;
    q.push_back(e);
  endtask

  task automatic push_ev(input int k, input logic [DW-1:0] v);
    exp_t e;
    e.kind = k; e.typ = 1'b0; e.nr = 2'd0; e.done = 1'b0; e.rid = 0; e.val = v;
    q.push_back(e);
  endtask

  task automatic wr(input logic a, input logic [DW-1:0] d);
    @(negedge clk); a0 = a; din = d; cs_n = 1'b0;
    @(negedge clk); wr_n = 1'b0;
    repeat (3) @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk); cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic rd(input logic a);
    @(negedge clk); a0 = a; cs_n = 1'b0;
    @(negedge clk); rd_n = 1'b0;
    repeat (4) @(negedge clk);
    rd_n = 1'b1;
    @(negedge clk); cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    chk(nm, q.size(), 0);
  endtask

  task automatic ev(input int k);
    exp_t e;
    if (q.size() == 0) begin
      chk("spurious_event_kind", k, 255);
    end else begin
      e = q.pop_front();
      chk("event_kind", k, e.kind);
      if (k == 0) begin
        chk("cmd_type", cmd_type, e.typ);
        chk("cmd_nr", cmd_nr, e.nr);
        chk("init_done", init_done, e.done);
        if (e.rid != 0) chk($sformatf("reg%0d", e.rid), reg_val(e.rid), e.val);
      end else if (k == 2) begin
        chk("dout", dout, e.val);
      end
    end
  endtask

  // Monitor: every DUT output event consumes one scoreboard entry.
  logic oe_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      oe_prev <= 1'b0;
    end else begin
      if (cmd_valid) ev(0);
      if (seq_err) ev(1);
      if (dout_oe && !oe_prev) ev(2);
      oe_prev <= dout_oe;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_regs", {icw1, icw2, icw3, icw4, imr, ocw2_data, dout}, 64'd0);
    chk("reset_ctrl", {cmd_valid, cmd_type, cmd_nr, init_done, seq_err, dout_oe}, 64'd0);
    rst = 1'b0;

    // UNINIT ignores non-ICW1 writes
    push_ev(1, '0);                 wr(1'b1, 8'h55);

    // single, IC4: ICW3 skipped
    push_cmd(1, 2'd0, 0, 1, 8'h13); wr(1'b0, 8'h13);
    push_cmd(1, 2'd1, 0, 2, 8'h20); wr(1'b1, 8'h20);
    push_cmd(1, 2'd3, 1, 4, 8'h01); wr(1'b1, 8'h01);
    drain("drain_seq1");
    chk("icw3_skipped", icw3, 8'h00);
    chk("init_done_seq1", init_done, 1'b1);

    // cascade, no IC4: ICW4 skipped
    push_cmd(1, 2'd0, 0, 1, 8'h10); wr(1'b0, 8'h10);
    push_cmd(1, 2'd1, 0, 2, 8'h08); wr(1'b1, 8'h08);
    push_cmd(1, 2'd2, 1, 3, 8'h04); wr(1'b1, 8'h04);
    drain("drain_seq2");
    chk("icw4_cleared", icw4, 8'h00);

    // OCW1 then ICW1 restart clears imr
    push_cmd(0, 2'd0, 1, 5, 8'hA5); wr(1'b1, 8'hA5);
    push_cmd(1, 2'd0, 0, 5, 8'h00); wr(1'b0, 8'h13);
    drain("drain_restart");
    chk("init_done_restart", init_done, 1'b0);
    push_cmd(1, 2'd1, 0, 2, 8'h20); wr(1'b1, 8'h20);
    push_cmd(1, 2'd3, 1, 4, 8'h01); wr(1'b1, 8'h01);

    // OCW2 and OCW3 read select
    push_cmd(0, 2'd1, 1, 6, 8'h20); wr(1'b0, 8'h20);
    isr_in = 8'h40; irr_in = 8'h81;
    push_cmd(0, 2'd2, 1, 0, '0);    wr(1'b0, 8'h0B);
    push_ev(2, 8'h40);              rd(1'b0);
    push_cmd(0, 2'd2, 1, 0, '0);    wr(1'b0, 8'h0A);
    push_ev(2, 8'h81);              rd(1'b0);
    push_cmd(0, 2'd0, 1, 5, 8'h3C); wr(1'b1, 8'h3C);
    push_ev(2, 8'h3C);              rd(1'b1);

    // RD and WR both low: error on entry, no commit; wr released first leaves a plain read
    push_ev(1, '0);
    push_ev(2, 8'h3C);
    @(negedge clk); a0 = 1'b1; din = 8'hFF; cs_n = 1'b0;
    @(negedge clk); wr_n = 1'b0; rd_n = 1'b0;
    repeat (4) @(negedge clk);
    wr_n = 1'b1;
    repeat (3) @(negedge clk);
    rd_n = 1'b1;
    @(negedge clk); cs_n = 1'b1;
    repeat (4) @(negedge clk);
    drain("drain_both_low");
    chk("imr_after_both_low", imr, 8'h3C);

    // a0=0 non-ICW1 in ICW2 is ignored, FSM stays in ICW2
    push_cmd(1, 2'd0, 0, 1, 8'h10); wr(1'b0, 8'h10);
    push_ev(1, '0);                 wr(1'b0, 8'h20);
    push_cmd(1, 2'd1, 0, 2, 8'h08); wr(1'b1, 8'h08);
    drain("drain_midseq");

    // reset while waiting for ICW3
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_regs", {icw1, icw2, icw3, icw4, imr, ocw2_data, dout}, 64'd0);
    chk("rst_mid_ctrl", {cmd_valid, cmd_type, cmd_nr, init_done, seq_err, dout_oe}, 64'd0);
    rst = 1'b0;
    push_ev(1, '0);                 wr(1'b1, 8'h04);
    drain("drain_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
